// File: rtl/sc_stream_decoder_pkg.sv
// Shared types and helpers for the stochastic stream decoder.
// The state encoding is shared so that the FSM localparams and any
// debug tooling agree on the same values.
package sc_dec_pkg;

  localparam int SC_DEC_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } sc_dec_state_t;

  // Returns 1 when a window count does not fit in w unsigned bits.
  // The only such value is exactly 2**w, which comes from an all-ones window.
  function automatic logic sc_dec_sat_hit(input logic [31:0] cnt, input int w);
    return cnt > ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/sc_stream_decoder_if.sv
// Stream-in / result-out bundle of the stochastic stream decoder.
// The decoder sits on the slave side; the producer/consumer sits on the master side.
interface sc_stream_decoder_if #(
  parameter int W = 8
);
  logic         start;
  logic         in_bit;
  logic         in_valid;
  logic         busy;
  logic [W-1:0] out_value;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output start, in_bit, in_valid, out_ready,
    input  busy, out_value, out_valid
  );

  modport slave (
    input  start, in_bit, in_valid, out_ready,
    output busy, out_value, out_valid
  );
endinterface

// File: rtl/sc_stream_decoder_ones_counter.sv
// Window counters for the stochastic stream decoder.
// samp_cnt counts valid samples and ones_cnt counts the '1' samples.
// Both counters are W+1 bits wide so that an all-ones window (2**W) fits.
// window_done is a combinational pulse on the cycle that takes the 2**W-th sample.
// ones_next includes the sample being taken this cycle, which lets the top
// register the final result on the same edge that samples the last bit.
module sc_ones_counter #(
  parameter int W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       in_bit,
  output logic [W:0] ones_next,
  output logic       window_done
);

  localparam logic [W:0] ONE      = {{W{1'b0}}, 1'b1};
  localparam logic [W:0] LAST_IDX = {1'b0, {W{1'b1}}};

  logic [W:0] samp_cnt;
  logic [W:0] ones_cnt;

  assign window_done = en && (samp_cnt == LAST_IDX);
  assign ones_next   = ones_cnt + {{W{1'b0}}, en & in_bit};

  // Clear at reset or window start; otherwise advance on every qualified sample.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      samp_cnt <= '0;
      ones_cnt <= '0;
    end else if (en) begin
      samp_cnt <= samp_cnt + ONE;
      ones_cnt <= ones_next;
    end
  end

endmodule

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary converter: counts the '1' bits of a unipolar stream over
// a window of 2**W valid samples and returns the count through valid/ready.
// Optional build macro: SC_DEC_BIPOLAR_EN selects a two's-complement bipolar
// result (count - 2**(W-1)); without it the result is unipolar unsigned.
// Note: rst_n is an active-high synchronous reset despite its name.
//
//  state | meaning
//  IDLE  | waiting for start; counters cleared on the start cycle
//  ACCUM | counting valid samples until the 2**W-th one is taken
//  HOLD  | result presented with out_valid=1 until out_ready
module sc_stream_decoder
  import sc_dec_pkg::*;
#(
  parameter int W = SC_DEC_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  sc_stream_decoder_if.slave bus
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_ACCUM = ACCUM;
  localparam logic [1:0] S_HOLD  = HOLD;

  logic [1:0]   state;
  logic [W-1:0] out_value;
  logic         cnt_clr;
  logic         cnt_en;
  logic         window_done;
  logic [W:0]   ones_next;
  logic [W-1:0] sat_value;
  logic [W-1:0] mapped_value;

  // Starting a window clears the counters; samples count only while accumulating,
  // so in_bit/in_valid on the start cycle are ignored.
  assign cnt_clr = (state == S_IDLE) && bus.start;
  assign cnt_en  = (state == S_ACCUM) && bus.in_valid;

  sc_ones_counter #(.W(W)) u_ones_counter (
    .clk         (clk),
    .rst         (rst_n),
    .clr         (cnt_clr),
    .en          (cnt_en),
    .in_bit      (bus.in_bit),
    .ones_next   (ones_next),
    .window_done (window_done)
  );

  // Clamp the W+1-bit count to the largest W-bit unsigned value.
  always_comb begin
    sat_value = ones_next[W-1:0];
    if (sc_dec_sat_hit(32'(ones_next), W)) begin
      sat_value = '1;
    end
  end

`ifdef SC_DEC_BIPOLAR_EN
  // Subtracting 2**(W-1) modulo 2**W is the same as flipping the top bit.
  localparam logic [W-1:0] SIGN_BIT = {1'b1, {(W-1){1'b0}}};
  assign mapped_value = sat_value ^ SIGN_BIT;
`else
  assign mapped_value = sat_value;
`endif

  // Window sequencing and result capture; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state     <= S_IDLE;
      out_value <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (window_done) begin
            state     <= S_HOLD;
            out_value <= mapped_value;
          end
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = (state == S_ACCUM);
  assign bus.out_valid = (state == S_HOLD);
  assign bus.out_value = out_value;

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Self-checking bench for sc_stream_decoder (W=8 and W=2 instances).
// Expected results are pushed into per-instance queues when a window is
// issued; a forked monitor pops and compares on every result handshake.
module tb_sc_stream_decoder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sc_stream_decoder_if #(.W(8)) bus ();
  sc_stream_decoder_if #(.W(2)) bus2 ();

  sc_stream_decoder #(.W(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  sc_stream_decoder #(.W(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  int errors = 0;
  int checks = 0;
  int bc;
  logic [7:0] q8[$];
  logic [1:0] q2[$];

  // Unipolar count -> expected output code for the selected build.
  function automatic int map8(input int u);
`ifdef SC_DEC_BIPOLAR_EN
    return (u + 128) % 256;
`else
    return u;
`endif
  endfunction

  function automatic int map2(input int u);
`ifdef SC_DEC_BIPOLAR_EN
    return (u + 2) % 4;
`else
    return u;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        if (q8.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result8: got %0d with no result expected", bus.out_value);
        end else begin
          check("result8", int'(bus.out_value), int'(q8.pop_front()));
        end
      end
      if (bus2.out_valid && bus2.out_ready) begin
        if (q2.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result2: got %0d with no result expected", bus2.out_value);
        end else begin
          check("result2", int'(bus2.out_value), int'(q2.pop_front()));
        end
      end
    end
  endtask

  // Start pulse with junk sample data that must not be counted.
  task automatic start8();
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_bit   = 1'b1;
    tick();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    check("busy_after_start", int'(bus.busy), 1);
  endtask

  // mode 0: all zeros, 1: all ones, 2: alternating 1/0, 3: one in every four.
  // stall: in_valid=0 (with in_bit=1) on every third cycle, starting with the first.
  task automatic send8(input int nvalid, input int mode, input bit stall, output int busy_cycles);
    int v;
    int c;
    v = 0;
    c = 0;
    busy_cycles = 0;
    while (v < nvalid) begin
      if (stall && (c % 3 == 0)) begin
        bus.in_valid = 1'b0;
        bus.in_bit   = 1'b1;
      end else begin
        bus.in_valid = 1'b1;
        case (mode)
          0:       bus.in_bit = 1'b0;
          1:       bus.in_bit = 1'b1;
          2:       bus.in_bit = (v % 2 == 0);
          default: bus.in_bit = (v % 4 == 0);
        endcase
        v++;
      end
      if (bus.busy) busy_cycles++;
      tick();
      c++;
    end
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
  endtask

  task automatic window2(input logic [3:0] bits, input string name);
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus2.in_valid = 1'b1;
      bus2.in_bit   = bits[i];
      tick();
    end
    bus2.in_valid = 1'b0;
    bus2.in_bit   = 1'b0;
    check(name, int'(bus2.out_valid), 1);
    tick();
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.in_bit     = 1'b0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b1;
    bus2.start     = 1'b0;
    bus2.in_bit    = 1'b0;
    bus2.in_valid  = 1'b0;
    bus2.out_ready = 1'b1;
    rst_n = 1'b1;
    repeat (3) tick();
    check("reset_busy", int'(bus.busy), 0);
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_out_value", int'(bus.out_value), 0);
    rst_n = 1'b0;
    tick();
    fork
      monitor();
    join_none

    // 1: all-ones window saturates
    start8();
    q8.push_back(8'(map8(255)));
    send8(256, 1, 1'b0, bc);
    check("t1_busy_cycles", bc, 256);
    check("t1_out_valid", int'(bus.out_valid), 1);
    check("t1_busy_done", int'(bus.busy), 0);
    tick();
    check("t1_valid_cleared", int'(bus.out_valid), 0);

    // 2: all-zeros window; start-cycle junk must not count
    start8();
    q8.push_back(8'(map8(0)));
    send8(256, 0, 1'b0, bc);
    check("t2_out_valid", int'(bus.out_valid), 1);
    tick();

    // 3: alternating with stalls every third cycle
    start8();
    q8.push_back(8'(map8(128)));
    send8(256, 2, 1'b1, bc);
    check("t3_busy_cycles", bc, 384);
    check("t3_out_valid", int'(bus.out_valid), 1);
    tick();

    // 4: back-pressure in HOLD, start ignored
    bus.out_ready = 1'b0;
    start8();
    q8.push_back(8'(map8(128)));
    send8(256, 2, 1'b0, bc);
    for (int i = 0; i < 10; i++) begin
      bus.start = (i == 3) || (i == 7);
      check("t4_hold_valid", int'(bus.out_valid), 1);
      check("t4_hold_value", int'(bus.out_value), map8(128));
      check("t4_hold_busy", int'(bus.busy), 0);
      tick();
    end
    bus.start     = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    check("t4_released", int'(bus.out_valid), 0);
    check("t4_no_new_window", int'(bus.busy), 0);
    tick();
    check("t4_still_idle", int'(bus.busy), 0);

    // 5: reset mid-window discards the partial count
    start8();
    send8(100, 1, 1'b0, bc);
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    check("t5_reset_busy", int'(bus.busy), 0);
    check("t5_reset_valid", int'(bus.out_valid), 0);
    start8();
    q8.push_back(8'(map8(64)));
    send8(256, 3, 1'b0, bc);
    check("t5_out_valid", int'(bus.out_valid), 1);
    tick();

    // reset in HOLD drops the pending result
    bus.out_ready = 1'b0;
    start8();
    send8(256, 1, 1'b0, bc);
    check("t5b_hold", int'(bus.out_valid), 1);
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    check("t5b_dropped", int'(bus.out_valid), 0);
    check("t5b_value_cleared", int'(bus.out_value), 0);
    bus.out_ready = 1'b1;
    tick();

    // 6: W=2 instance, plain count and saturation
    q2.push_back(2'(map2(3)));
    window2(4'b1011, "t6_valid_1101");
    q2.push_back(2'(map2(3)));
    window2(4'b1111, "t6_valid_1111");

    repeat (2) tick();
    check("q8_drained", q8.size(), 0);
    check("q2_drained", q2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
